// File: rtl/spi_frame_rx.sv
// SPI slave that assembles serial words into an image-pixel stream or a one-hot
// class label, selected by a command word at the start of each ss_n frame.
module spi_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int PIX_COUNT   = 784,
  parameter int NUM_CLASSES = 10,
  parameter int MSB_FIRST   = 0,
  parameter int SAMPLE_FALL = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sck,
  input  logic                         ss_n,
  input  logic                         mosi,
  input  logic                         data_ready,
  output logic [DATA_W-1:0]            pix_data,
  output logic                         pix_valid,
  output logic [$clog2(PIX_COUNT)-1:0] pix_addr,
  output logic                         frame_done,
  output logic                         calc_cost,
  output logic [NUM_CLASSES-1:0]       expected_label,
  output logic                         label_err,
  output logic                         abort,
  output logic                         busy
);

  localparam int   ADDR_W   = $clog2(PIX_COUNT);
  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic SCK_IDLE = (SAMPLE_FALL != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_PIX,
    S_LABEL,
    S_DONE_PIX,
    S_DONE_LBL,
    S_DRAIN
  } state_t;

  logic [1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic       sck_prev_q, ss_prev_q;
  logic       sck_s, ss_s, mosi_s;
  logic       sck_edge, bit_strobe, ss_fall, ss_rise;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              word_strobe_q, word_strobe_d;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]      pix_data_q, pix_data_d;
  logic [ADDR_W-1:0]      pix_addr_q, pix_addr_d;
  logic                   pix_valid_q, pix_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   calc_cost_q, calc_cost_d;
  logic                   abort_q, abort_d;
  logic [NUM_CLASSES-1:0] label_q, label_d;
  logic                   label_err_q, label_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= {2{SCK_IDLE}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= SCK_IDLE;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      ss_sync_q   <= {ss_sync_q[0], ss_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sck_prev_q  <= sck_sync_q[1];
      ss_prev_q   <= ss_sync_q[1];
    end
  end

  assign sck_s      = sck_sync_q[1];
  assign ss_s       = ss_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign sck_edge   = (SAMPLE_FALL != 0) ? (sck_prev_q & ~sck_s) : (sck_s & ~sck_prev_q);
  assign bit_strobe = sck_edge & ~ss_s;
  assign ss_fall    = ss_prev_q & ~ss_s;
  assign ss_rise    = ~ss_prev_q & ss_s;

  // word_strobe is registered so the FSM reads a settled shift_q; that stage
  // is what places pix_valid three clocks after the sck edge is captured.
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_strobe_d = 1'b0;
    if (ss_s) begin
      bit_cnt_d = '0;
    end else if (bit_strobe) begin
      if (MSB_FIRST != 0) shift_d = {shift_q[DATA_W-2:0], mosi_s};
      else                shift_d = {mosi_s, shift_q[DATA_W-1:1]};
      if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
        bit_cnt_d     = '0;
        word_strobe_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_strobe_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_strobe_q <= word_strobe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pix_data_d   = pix_data_q;
    pix_addr_d   = pix_addr_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    calc_cost_d  = 1'b0;
    abort_d      = 1'b0;
    label_d      = label_q;
    label_err_d  = label_err_q;
    // A truncated frame takes priority over any word finishing in the same cycle.
    if (ss_rise && (state_q inside {S_CMD, S_PIX, S_LABEL})) begin
      abort_d = 1'b1;
      idx_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (ss_fall) state_d = S_CMD;
        S_CMD: begin
          if (word_strobe_q) begin
            if (data_ready && shift_q == DATA_W'(0))      state_d = S_PIX;
            else if (data_ready && shift_q == DATA_W'(1)) state_d = S_LABEL;
            else                                          state_d = S_DRAIN;
          end
        end
        S_PIX: begin
          if (word_strobe_q) begin
            pix_data_d  = shift_q;
            pix_addr_d  = idx_q;
            pix_valid_d = 1'b1;
            if (idx_q == ADDR_W'(PIX_COUNT - 1)) state_d = S_DONE_PIX;
            else                                 idx_d   = idx_q + ADDR_W'(1);
          end
        end
        S_LABEL: begin
          if (word_strobe_q) begin
            if (32'(shift_q) < $unsigned(NUM_CLASSES)) begin
              label_d     = NUM_CLASSES'(1) << shift_q;
              label_err_d = 1'b0;
              state_d     = S_DONE_LBL;
            end else begin
              label_err_d = 1'b1;
              state_d     = S_DRAIN;
            end
          end
        end
        S_DONE_PIX: begin
          frame_done_d = 1'b1;
          idx_d        = '0;
          state_d      = S_DRAIN;
        end
        S_DONE_LBL: begin
          calc_cost_d = 1'b1;
          state_d     = S_DRAIN;
        end
        S_DRAIN: if (ss_s) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      calc_cost_q  <= 1'b0;
      abort_q      <= 1'b0;
      label_q      <= '0;
      label_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pix_data_q   <= pix_data_d;
      pix_addr_q   <= pix_addr_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      calc_cost_q  <= calc_cost_d;
      abort_q      <= abort_d;
      label_q      <= label_d;
      label_err_q  <= label_err_d;
    end
  end

  assign pix_data       = pix_data_q;
  assign pix_valid      = pix_valid_q;
  assign pix_addr       = pix_addr_q;
  assign frame_done     = frame_done_q;
  assign calc_cost      = calc_cost_q;
  assign abort          = abort_q;
  assign expected_label = label_q;
  assign label_err      = label_err_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench: instance A uses defaults (LSB-first, rising sample); instance B
// is 12-bit MSB-first, falling-sample with a 4-word frame.
`timescale 1ns/1ps
module tb_spi_frame_rx;

  localparam int K_PIX = 0, K_FD = 1, K_CC = 2, K_AB = 3;

  typedef struct {
    int     kind;
    longint addr;
    longint data;
    longint label;
  } ev_t;

  logic clk = 1'b0;
  logic rst, sck_a, sck_b, ss_a, ss_b, mosi, dr;

  logic [7:0]  a_data;  logic a_pv; logic [9:0] a_addr; logic a_fd, a_cc;
  logic [9:0]  a_label; logic a_err, a_ab, a_busy;
  logic [11:0] b_data;  logic b_pv; logic [1:0] b_addr; logic b_fd, b_cc;
  logic [9:0]  b_label; logic b_err, b_ab, b_busy;

  int total = 0;
  int bad   = 0;
  ev_t qa[$];
  ev_t qb[$];
  longint exp_label = 0;
  longint exp_err   = 0;

  always #5 clk = ~clk;

  spi_frame_rx dut_a (
    .clk(clk), .rst(rst), .sck(sck_a), .ss_n(ss_a), .mosi(mosi), .data_ready(dr),
    .pix_data(a_data), .pix_valid(a_pv), .pix_addr(a_addr), .frame_done(a_fd),
    .calc_cost(a_cc), .expected_label(a_label), .label_err(a_err), .abort(a_ab),
    .busy(a_busy)
  );

  spi_frame_rx #(.DATA_W(12), .PIX_COUNT(4), .NUM_CLASSES(10), .MSB_FIRST(1), .SAMPLE_FALL(1)) dut_b (
    .clk(clk), .rst(rst), .sck(sck_b), .ss_n(ss_b), .mosi(mosi), .data_ready(dr),
    .pix_data(b_data), .pix_valid(b_pv), .pix_addr(b_addr), .frame_done(b_fd),
    .calc_cost(b_cc), .expected_label(b_label), .label_err(b_err), .abort(b_ab),
    .busy(b_busy)
  );

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic void push(input bit sel, input int kind, input longint addr,
                               input longint data, input longint label);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.label = label;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endfunction

  task automatic observe(input bit sel, input logic pv, input logic fd, input logic cc,
                         input logic ab, input longint addr, input longint data,
                         input longint label, input longint err);
    int  n;
    int  kind;
    ev_t e;
    n = int'(pv) + int'(fd) + int'(cc) + int'(ab);
    if (n > 1) begin
      chk(sel ? "B pulses exclusive" : "A pulses exclusive", longint'(n), 1);
    end else if (n == 1) begin
      kind = pv ? K_PIX : fd ? K_FD : cc ? K_CC : K_AB;
      if ((sel ? qb.size() : qa.size()) == 0) begin
        total++;
        bad++;
        $display("FAIL %s unexpected event kind=%0d required=none at %0t",
                 sel ? "B" : "A", kind, $time);
      end else begin
        e = sel ? qb.pop_front() : qa.pop_front();
        chk(sel ? "B event kind" : "A event kind", longint'(kind), longint'(e.kind));
        if (kind == K_PIX && e.kind == K_PIX) begin
          chk(sel ? "B pix_addr" : "A pix_addr", addr, e.addr);
          chk(sel ? "B pix_data" : "A pix_data", data, e.data);
        end
        if (kind == K_CC && e.kind == K_CC) begin
          chk("A expected_label at calc_cost", label, e.label);
          chk("A label_err at calc_cost", err, 0);
        end
      end
    end
  endtask

  always @(negedge clk)
    if (!rst) observe(1'b0, a_pv, a_fd, a_cc, a_ab, longint'(a_addr), longint'(a_data),
                      longint'(a_label), longint'(a_err));

  always @(negedge clk)
    if (!rst) observe(1'b1, b_pv, b_fd, b_cc, b_ab, longint'(b_addr), longint'(b_data),
                      longint'(b_label), longint'(b_err));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A shifts LSB-first over 8 bits; B MSB-first over 12 bits. Both sample on
  // the first edge away from their idle level.
  task automatic send_bits(input bit sel, input int unsigned w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = sel ? w[11-i] : w[i];
      cyc(2);
      if (sel) sck_b = 1'b0; else sck_a = 1'b1;
      cyc(2);
      if (sel) sck_b = 1'b1; else sck_a = 1'b0;
    end
  endtask

  task automatic send_word(input bit sel, input int unsigned w);
    send_bits(sel, w, sel ? 12 : 8);
  endtask

  task automatic ss_lo(input bit sel);
    if (sel) ss_b = 1'b0; else ss_a = 1'b0;
    cyc(6);
  endtask

  task automatic ss_hi(input bit sel);
    cyc(4);
    if (sel) ss_b = 1'b1; else ss_a = 1'b1;
    cyc(8);
  endtask

  task automatic do_label(input int unsigned v);
    ss_lo(0);
    send_word(0, 1);
    if (v < 10) begin
      exp_label = longint'(1) << v;
      exp_err   = 0;
      push(0, K_CC, 0, 0, exp_label);
    end else begin
      exp_err = 1;
    end
    send_word(0, v);
    ss_hi(0);
    chk("A expected_label after label frame", longint'(a_label), exp_label);
    chk("A label_err after label frame", longint'(a_err), exp_err);
  endtask

  task automatic pix_frame(input bit sel, input int count, input bit ramp);
    int unsigned d;
    ss_lo(sel);
    send_word(sel, 0);
    for (int i = 0; i < count; i++) begin
      d = ramp ? (i % 256) : (sel ? $urandom_range(0, 4095) : $urandom_range(0, 255));
      push(sel, K_PIX, i, d, 0);
      if (i == count - 1) push(sel, K_FD, 0, 0, 0);
      send_word(sel, d);
    end
    ss_hi(sel);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d;
    rst = 1'b1; ss_a = 1'b1; ss_b = 1'b1; sck_a = 1'b0; sck_b = 1'b1; mosi = 1'b0; dr = 1'b1;
    cyc(4);
    chk("reset pix_valid", longint'(a_pv), 0);
    chk("reset pix_addr", longint'(a_addr), 0);
    chk("reset pix_data", longint'(a_data), 0);
    chk("reset frame_done", longint'(a_fd), 0);
    chk("reset calc_cost", longint'(a_cc), 0);
    chk("reset expected_label", longint'(a_label), 0);
    chk("reset label_err", longint'(a_err), 0);
    chk("reset abort", longint'(a_ab), 0);
    chk("reset busy", longint'(a_busy), 0);
    rst = 1'b0;
    cyc(4);

    pix_frame(0, 784, 1'b1);
    chk("A busy after frame", longint'(a_busy), 0);

    do_label(7);
    do_label(12);
    do_label(3);
    repeat (6) do_label($urandom_range(0, 15));

    // Unknown command drains silently.
    ss_lo(0);
    send_word(0, $urandom_range(2, 255));
    send_word(0, 0);
    chk("A busy in drain after bad cmd", longint'(a_busy), 1);
    ss_hi(0);
    chk("A busy after bad cmd", longint'(a_busy), 0);

    // Truncated pixel frame, then a full frame must restart at address 0.
    ss_lo(0);
    send_word(0, 0);
    for (int i = 0; i < 5; i++) begin
      d = $urandom_range(0, 255);
      push(0, K_PIX, i, d, 0);
      send_word(0, d);
    end
    push(0, K_AB, 0, 0, 0);
    ss_hi(0);
    chk("A busy after abort", longint'(a_busy), 0);
    chk("A pix_data retained after abort", longint'(a_data), longint'(d));
    pix_frame(0, 784, 1'b0);

    // Downstream not ready: the frame is drained.
    dr = 1'b0;
    ss_lo(0);
    send_word(0, 0);
    repeat (3) send_word(0, $urandom_range(0, 255));
    cyc(4);
    chk("A busy in drain without ready", longint'(a_busy), 1);
    ss_hi(0);
    chk("A busy after drain", longint'(a_busy), 0);
    dr = 1'b1;

    // Reset mid-frame: no abort, label state cleared.
    do_label(5);
    ss_lo(0);
    send_word(0, 0);
    for (int i = 0; i < 2; i++) begin
      d = $urandom_range(0, 255);
      push(0, K_PIX, i, d, 0);
      send_word(0, d);
    end
    cyc(8);
    rst = 1'b1;
    cyc(2);
    ss_a = 1'b1;
    rst  = 1'b0;
    exp_label = 0;
    exp_err   = 0;
    cyc(10);
    chk("A label after mid-frame reset", longint'(a_label), exp_label);
    chk("A pix_addr after mid-frame reset", longint'(a_addr), 0);
    chk("A busy after mid-frame reset", longint'(a_busy), 0);
    pix_frame(0, 784, 1'b0);

    // Instance B: 12-bit MSB-first word, then a 5-bit fragment before ss_n rises.
    ss_lo(1);
    send_word(1, 0);
    push(1, K_PIX, 0, 'hA01, 0);
    send_word(1, 'hA01);
    send_bits(1, $urandom_range(0, 4095), 5);
    push(1, K_AB, 0, 0, 0);
    ss_hi(1);
    chk("B busy after fragment", longint'(b_busy), 0);
    pix_frame(1, 4, 1'b0);
    pix_frame(1, 4, 1'b0);

    for (int k = 0; k < 200 && (qa.size() != 0 || qb.size() != 0); k++) cyc(1);
    chk("A scoreboard drained", longint'(qa.size()), 0);
    chk("B scoreboard drained", longint'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per SPI word (4..16).
REQ-002 SHALL have parameter PIX_COUNT, default 784, pixel words per image frame (≥2).
REQ-003 SHALL have parameter NUM_CLASSES, default 10, width of one-hot label output (2..2**DATA_W).
REQ-004 SHALL have parameter MSB_FIRST, default 0, 1 = first received bit lands in bit DATA_W-1, 0 = first bit lands in bit 0.
REQ-005 SHALL have parameter SAMPLE_FALL, default 0, 0 = sample mosi on sck rising edge, 1 = on falling edge.
REQ-006 SHALL have one clock and synchronous active-high reset, ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: sck in 1, asynchronous SPI clock; ss_n in 1, asynchronous active-low select; mosi in 1, asynchronous serial data.
REQ-008 SHALL have ports: data_ready in 1, downstream permits a new frame; pix_data out DATA_W, last pixel word; pix_valid out 1, one-cycle pixel write strobe.
REQ-009 SHALL have ports: pix_addr out clog2(PIX_COUNT), index of pix_data; frame_done out 1, one-cycle pulse after last pixel; calc_cost out 1, one-cycle pulse after label loaded.
REQ-010 SHALL have ports: expected_label out NUM_CLASSES, one-hot label; label_err out 1, sticky out-of-range flag; abort out 1, one-cycle pulse on truncated frame; busy out 1, state != IDLE.

Function
REQ-011 SHALL pass sck, ss_n, mosi each through a 2-flop synchronizer before any use; ss_n synchronizer resets to 1.
REQ-012 SHALL detect the selected sample edge on synchronized sck qualified by synchronized ss_n = 0; all shifting/counting happens only on that single-cycle strobe.
REQ-013 SHALL shift synchronized mosi into a DATA_W shift register per strobe, bit order per MSB_FIRST; a bit counter wraps at DATA_W and produces word_strobe on the DATA_W-th bit.
REQ-014 SHALL clear the bit counter whenever synchronized ss_n is 1, discarding partial words.
REQ-015 SHALL implement states IDLE, CMD, PIX, LABEL, DONE_PIX, DONE_LBL, DRAIN.
REQ-016 IDLE -> CMD on synchronized ss_n falling; CMD on word_strobe: word 0x00 and data_ready=1 -> PIX, word 0x01 and data_ready=1 -> LABEL, any other case -> DRAIN.
REQ-017 PIX: each word_strobe registers pix_data, pulses pix_valid next cycle with pix_addr = word index (0 first), increments index; after index PIX_COUNT-1 written -> DONE_PIX.
REQ-018 DONE_PIX: frame_done pulses one cycle, index clears -> DRAIN.
REQ-019 LABEL: first word_strobe: value < NUM_CLASSES loads expected_label = one-hot(value) -> DONE_LBL; value ≥ NUM_CLASSES leaves expected_label unchanged, sets label_err -> DRAIN.
REQ-020 DONE_LBL: calc_cost pulses one cycle -> DRAIN.
REQ-021 DRAIN ignores all words; -> IDLE when synchronized ss_n is 1.
REQ-022 Synchronized ss_n rising while in CMD, PIX or LABEL SHALL pulse abort one cycle, clear pixel index, -> IDLE; pix_data/expected_label retain values.
REQ-023 Latency: pix_valid SHALL assert exactly 3 clk cycles after the clk edge whose first synchronizer flop captures the final sampled sck edge of the word.
REQ-024 label_err SHALL clear only on rst or on a successful label load.
REQ-025 frame_done, calc_cost, abort, pix_valid SHALL never be high in the same cycle.

Reset
REQ-026 On rst: state IDLE, pix_data 0, pix_valid 0, pix_addr 0, frame_done 0, calc_cost 0, expected_label 0, label_err 0, abort 0, busy 0, shift register and counters 0, synchronizers to idle values (sck per SAMPLE_FALL inactive level, ss_n 1, mosi 0).
REQ-027 rst asserted mid-frame SHALL take effect at next clk edge with no abort pulse; the in-flight frame is discarded.

Verification
REQ-028 Defaults, data_ready=1, send 0x00 then 784 words i mod 256 -> 784 pix_valid pulses, pix_addr 0..783, pix_data matches, one frame_done after last.
REQ-029 Send 0x01, 0x07 -> expected_label = 10'b0010000000, one calc_cost pulse, label_err 0.
REQ-030 Send 0x01, 0x0C -> label_err 1, expected_label unchanged, no calc_cost; then 0x01, 0x03 -> label_err 0, expected_label 10'b0000001000.
REQ-031 Send 0x00 then 5 words, raise ss_n -> abort one pulse, busy 0; next full frame starts at pix_addr 0.
REQ-032 data_ready=0, send 0x00 + words -> no pix_valid, DRAIN until ss_n high.
REQ-033 MSB_FIRST=1, DATA_W=12, bits 1010_0000_0001 after 0x000 command -> pix_data 12'hA01 at pix_addr 0; 5-bit partial word then ss_n high -> no strobe, counter cleared.
